l0_skew_buffer: RTL and testbench

- Row-parallel input buffer sitting directly west of the MAC tile array.
- Accepts one full column vector (one word per row) per push.
- Drives each row's west-edge data bus (in_w) and 2-bit instruction bus (inst_w) with a diagonal skew: row r is issued r cycles after row 0, so operands and instructions reach the array wavefront-aligned.
- Kernel-load and execute traffic both pass through this block.

---
 rtl/l0_skew_buffer.sv | 140 ++++++++++++++
 tb/tb_l0_skew_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_skew_buffer.sv
// -----------------------------------------------------------------------------
// l0_skew_buffer
//
// Row-parallel input buffer west of the MAC tile array. Every push writes one
// word into each of `row` independent circular FIFOs. An issue request starts
// a diagonal wavefront: row 0 pops first and row r pops r cycles later, so the
// data words and their 2-bit instructions reach the array aligned per diagonal.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   reset     asynchronous active-low reset, clears all state while low
//   wr        push request, one vector into every row FIFO (dropped when full)
//   in        push vector, row r at [r*bw +: bw]
//   full      some row FIFO holds depth entries
//   rd        issue request (row 0 now, row r r cycles later)
//   inst_in   instruction sent with the issue ([1]=execute, [0]=kernel load)
//   ready     an issue would be accepted this cycle
//   out       per-row data to the array, row r at [r*bw +: bw]
//   inst_out  per-row instruction, row r at [2r +: 2], 2'b00 when not valid
//   valid     per-row flag: the out/inst_out slice is a fresh issue
//
// Handshake: an issue is taken on a rising edge where rd && ready. A push is
// taken on a rising edge where wr && !full; wr while full is silently dropped.
// valid[r] is a one-cycle flag qualifying out[r] and inst_out[r]; there is no
// backpressure from the array side.
// -----------------------------------------------------------------------------
module l0_skew_buffer #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [row*bw-1:0]   in,
    output logic                full,
    input  logic                rd,
    input  logic [1:0]          inst_in,
    output logic                ready,
    output logic [row*bw-1:0]   out,
    output logic [row*2-1:0]    inst_out,
    output logic [row-1:0]      valid
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = depth[aw:0];

    // Storage is not reset: pointers define which entries are live.
    logic [bw-1:0]        mem [row][depth];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [row-1:0][aw:0] wptr;
    logic [row-1:0][aw:0] rptr;
    logic [row-1:0][aw:0] occ;

    // Skew pipeline: stage r holds the issue that row r pops on the next edge.
    logic [row-1:0]       stage_go;
    logic [row-1:0][1:0]  stage_inst;

    logic                 push;
    logic                 issue;

    // Occupancy per row and full flag. The deepest row is always the one that
    // has popped least, so "any row at depth" equals "max occupancy at depth".
    always_comb begin
        full = 1'b0;
        for (int r = 0; r < row; r++) begin
            occ[r] = wptr[r] - rptr[r];
            if (occ[r] == full_cnt) begin
                full = 1'b1;
            end
        end
    end

    // Row 0 has at most one pop in flight (the issue sitting in stage 0).
    // Rows receive identical pushes and pop later than row 0, so a row 0 entry
    // that is not yet claimed guarantees every other row can pop in turn.
    assign ready = (occ[0] - {{aw{1'b0}}, stage_go[0]}) != '0;
    assign issue = rd && ready;
    assign push  = wr && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            for (int r = 0; r < row; r++) begin
                mem[r][wptr[r][aw-1:0]] <= in[r*bw +: bw];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            for (int r = 0; r < row; r++) begin
                if (push) begin
                    wptr[r] <= wptr[r] + 1'b1;
                end
                if (stage_go[r]) begin
                    rptr[r] <= rptr[r] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_go   <= '0;
            stage_inst <= '0;
        end else begin
            stage_go[0]   <= issue;
            stage_inst[0] <= inst_in;
            for (int r = 1; r < row; r++) begin
                stage_go[r]   <= stage_go[r-1];
                stage_inst[r] <= stage_inst[r-1];
            end
        end
    end

    // Output registers: data holds when idle, instruction is forced to no-op
    // so a tile never sees a stale load/execute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out      <= '0;
            inst_out <= '0;
            valid    <= '0;
        end else begin
            for (int r = 0; r < row; r++) begin
                valid[r] <= stage_go[r];
                if (stage_go[r]) begin
                    out[r*bw +: bw]    <= mem[r][rptr[r][aw-1:0]];
                    inst_out[2*r +: 2] <= stage_inst[r];
                end else begin
                    inst_out[2*r +: 2] <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_l0_skew_buffer.sv
// -----------------------------------------------------------------------------
// tb_l0_skew_buffer
//
// Reference model: the buffer is a log of pushed vectors plus, per row, a count
// of entries already consumed. An issue accepted at edge N consumes row r's
// next entry at edge N+1+r. Fullness and readiness follow from those counts.
// -----------------------------------------------------------------------------
module tb_l0_skew_buffer;

    localparam int n_row   = 8;
    localparam int bw      = 4;
    localparam int depth   = 16;
    localparam int vw      = n_row * bw;
    localparam int max_cyc = 4096;

    // ---------------- clock / reset ----------------
    logic                clk;
    logic                reset;
    logic                wr;
    logic [vw-1:0]       in_d;
    logic                full;
    logic                rd;
    logic [1:0]          inst_in;
    logic                ready;
    logic [vw-1:0]       out_d;
    logic [2*n_row-1:0]  inst_out;
    logic [n_row-1:0]    valid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    l0_skew_buffer #(.row(n_row), .bw(bw), .depth(depth)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .in       (in_d),
        .full     (full),
        .rd       (rd),
        .inst_in  (inst_in),
        .ready    (ready),
        .out      (out_d),
        .inst_out (inst_out),
        .valid    (valid)
    );

    // ---------------- scoreboard / model ----------------
    logic [vw-1:0]       exp_q[$];          // every accepted push, in order
    int                  popped [n_row];    // entries consumed per row
    bit                  go_at [max_cyc];   // issue accepted at edge index
    logic [1:0]          inst_at [max_cyc];
    int                  cyc;
    logic [vw-1:0]       exp_out;
    logic [2*n_row-1:0]  exp_inst;
    logic [n_row-1:0]    exp_valid;

    int checks;
    int errors;

    logic pr;
    logic pf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int r = 0; r < n_row; r++) popped[r] = 0;
        for (int i = 0; i < max_cyc; i++) go_at[i] = 1'b0;
        exp_out   = '0;
        exp_inst  = '0;
        exp_valid = '0;
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive inputs, check ready/full before the edge, advance
    // the model across the edge, then check the registered outputs after it.
    task automatic step(input logic s_wr, input logic [vw-1:0] s_in,
                        input logic s_rd, input logic [1:0] s_inst,
                        output logic pre_ready, output logic pre_full);
        bit            full_m;
        bit            ready_m;
        int            inflight;
        int            n;
        logic [vw-1:0] head;
        wr      = s_wr;
        in_d    = s_in;
        rd      = s_rd;
        inst_in = s_inst;
        #1;
        full_m = 1'b0;
        for (int r = 0; r < n_row; r++) begin
            if (exp_q.size() - popped[r] == depth) full_m = 1'b1;
        end
        inflight = (cyc > 0 && go_at[cyc-1]) ? 1 : 0;
        ready_m  = (exp_q.size() - popped[0] - inflight) > 0;
        pre_ready = ready;
        pre_full  = full;
        chk("ready", {63'b0, ready}, {63'b0, ready_m});
        chk("full",  {63'b0, full},  {63'b0, full_m});

        exp_valid = '0;
        exp_inst  = '0;
        for (int r = 0; r < n_row; r++) begin
            n = cyc - 1 - r;
            if (n >= 0 && go_at[n] && popped[r] < exp_q.size()) begin
                head = exp_q[popped[r]];
                exp_out[r*bw +: bw]  = head[r*bw +: bw];
                exp_inst[2*r +: 2]   = inst_at[n];
                exp_valid[r]         = 1'b1;
                popped[r]++;
            end
        end
        if (s_wr && !full_m) exp_q.push_back(s_in);
        if (cyc >= max_cyc) begin
            $display("FAIL cycle_budget: cycle %0d exceeds model table %0d", cyc, max_cyc);
            $fatal(1, "cycle budget");
        end
        go_at[cyc]   = s_rd && ready_m;
        inst_at[cyc] = s_inst;
        cyc++;

        @(posedge clk);
        #1;
        chk("valid",    {56'b0, valid},    {56'b0, exp_valid});
        chk("inst_out", {48'b0, inst_out}, {48'b0, exp_inst});
        chk("out",      {32'b0, out_d},    {32'b0, exp_out});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 2'b00, pr, pf);
    endtask

    task automatic do_reset(input int n);
        wr = 1'b0; rd = 1'b0; inst_in = 2'b00; in_d = '0;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_valid",    {56'b0, valid},    64'h0);
        chk("rst_inst_out", {48'b0, inst_out}, 64'h0);
        chk("rst_out",      {32'b0, out_d},    64'h0);
        chk("rst_ready",    {63'b0, ready},    64'h0);
        chk("rst_full",     {63'b0, full},     64'h0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
    endtask

    // ---------------- vector table: skew timing ----------------
    typedef struct {
        logic               wr;
        logic [vw-1:0]      din;
        logic               rd;
        logic [1:0]         inst;
        logic               exp_ready;
        logic               exp_full;
        logic [n_row-1:0]   exp_valid;
        logic [2*n_row-1:0] exp_inst;
        logic [vw-1:0]      exp_out;
    } vec_t;

    vec_t tbl [n_row+4];

    task automatic fill_table();
        logic [vw-1:0] skew_vec;
        logic [vw-1:0] acc;
        for (int r = 0; r < n_row; r++) skew_vec[r*bw +: bw] = bw'(r + 1);
        tbl[0] = '{1'b1, skew_vec, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0, '0};
        tbl[1] = '{1'b0, '0, 1'b1, 2'b10, 1'b1, 1'b0, '0, '0, '0};
        acc = '0;
        for (int k = 0; k < n_row; k++) begin
            logic [2*n_row-1:0] iv;
            iv = '0;
            iv[2*k +: 2] = 2'b10;
            acc[k*bw +: bw] = bw'(k + 1);
            tbl[2+k] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0,
                         n_row'(1) << k, iv, acc};
        end
        tbl[n_row+2] = '{1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0, '0, skew_vec};
        tbl[n_row+3] = tbl[n_row+2];
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < n_row + 4; i++) begin
            step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].inst, pr, pf);
            chk($sformatf("%s%0d_ready", tag, i), {63'b0, pr}, {63'b0, tbl[i].exp_ready});
            chk($sformatf("%s%0d_full", tag, i),  {63'b0, pf}, {63'b0, tbl[i].exp_full});
            chk($sformatf("%s%0d_valid", tag, i), {56'b0, valid}, {56'b0, tbl[i].exp_valid});
            chk($sformatf("%s%0d_inst", tag, i),  {48'b0, inst_out}, {48'b0, tbl[i].exp_inst});
            chk($sformatf("%s%0d_out", tag, i),   {32'b0, out_d}, {32'b0, tbl[i].exp_out});
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [bw-1:0] kw;
        logic [vw-1:0] rv;
        int            row0_cnt;
        int            row7_cnt;
        int            last0;
        int            last7;
        int            issued;
        int            bound;
        logic [bw-1:0] got0 [$];

        checks = 0;
        errors = 0;
        cyc    = 0;
        fill_table();

        // Reset / idle
        do_reset(3);
        idle(4);

        // Skew timing
        run_table("skew");

        // Full / drop: 17 pushes, the 17th is dropped
        do_reset(2);
        for (int k = 0; k < 17; k++) begin
            kw = k[bw-1:0];
            step(1'b1, {n_row{kw}}, 1'b0, 2'b00, pr, pf);
            if (k == 15) chk("full_before_16th", {63'b0, pf}, 64'h0);
            if (k == 16) chk("full_after_16th",  {63'b0, pf}, 64'h1);
        end
        got0.delete();
        last0 = -1; last7 = -1; row7_cnt = 0; issued = 0;
        for (int k = 0; k < 24; k++) begin
            step(1'b0, '0, (k < 16), 2'b10, pr, pf);
            if (k < 16 && pr) issued++;
            if (valid[0]) begin got0.push_back(out_d[bw-1:0]); last0 = k; end
            if (valid[n_row-1]) begin row7_cnt++; last7 = k; end
        end
        chk("drop_issued", 64'(issued), 64'd16);
        chk("drop_row0_cnt", 64'(got0.size()), 64'd16);
        for (int k = 0; k < got0.size(); k++) chk($sformatf("drop_row0_%0d", k), {60'b0, got0[k]}, 64'(k));
        chk("drop_row7_cnt", 64'(row7_cnt), 64'd16);
        chk("drop_last0", 64'(last0), 64'd16);
        chk("drop_last7", 64'(last7), 64'd23);
        step(1'b0, '0, 1'b1, 2'b01, pr, pf);
        chk("drop_empty_ready", {63'b0, pr}, 64'h0);
        chk("drop_empty_full",  {63'b0, pf}, 64'h0);
        idle(2);

        // Simultaneous push/pop across pointer wrap
        do_reset(2);
        for (int k = 0; k < depth - 1; k++) begin
            rv = $urandom;
            step(1'b1, rv, 1'b0, 2'b00, pr, pf);
        end
        for (int k = 0; k < 40; k++) begin
            rv = $urandom;
            step(1'b1, rv, 1'b1, 2'($urandom_range(0, 3)), pr, pf);
        end
        bound = 0;
        do begin
            step(1'b0, '0, 1'b1, 2'b01, pr, pf);
            bound++;
        end while (pr && bound < 64);
        chk("drain_bound", 64'(bound < 64), 64'h1);
        idle(n_row + 1);

        // Empty guard: rd held high with two entries
        do_reset(2);
        step(1'b1, 32'h1111_1111, 1'b0, 2'b00, pr, pf);
        step(1'b1, 32'h2222_2222, 1'b0, 2'b00, pr, pf);
        row0_cnt = 0; row7_cnt = 0; issued = 0;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, '0, 1'b1, 2'b10, pr, pf);
            if (pr) issued++;
            if (valid[0]) row0_cnt++;
            if (valid[n_row-1]) row7_cnt++;
        end
        chk("guard_issued", 64'(issued), 64'd2);
        chk("guard_row0", 64'(row0_cnt), 64'd2);
        chk("guard_row7", 64'(row7_cnt), 64'd2);
        chk("guard_ready_end", {63'b0, ready}, 64'h0);

        // Mid-operation reset with rows 3..7 still pending
        step(1'b1, 32'h5555_5555, 1'b0, 2'b00, pr, pf);
        step(1'b0, '0, 1'b1, 2'b10, pr, pf);
        idle(3);
        chk("mid_pre_valid", {56'b0, valid}, 64'h04);
        do_reset(2);
        run_table("post");

        // Randomized traffic against the model
        do_reset(2);
        for (int k = 0; k < 800; k++) begin
            rv = $urandom;
            step($urandom_range(0, 99) < 60, rv, $urandom_range(0, 99) < 55,
                 2'($urandom_range(0, 3)), pr, pf);
        end
        idle(n_row + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
